// File: rtl/mem_stage_if.sv
// EXE->MEM, data-SRAM response, MEM->WB and forwarding signals of the MEM stage.
// The stage takes the slave modport; its surroundings (EXE, SRAM, WB, decode) take master.
interface mem_stage_if #(parameter int SIDE_W = 80);
  logic              es_to_ms_valid;
  logic              ms_allowin;
  logic [31:0]       es_pc;
  logic [3:0]        es_gr_we;
  logic [4:0]        es_dest;
  logic [31:0]       es_alu_result;
  logic [31:0]       es_rt_value;
  logic [6:0]        es_load_op;
  logic              es_mem_req;
  logic [SIDE_W-1:0] es_side_bus;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              flush;
  logic              ws_allowin;
  logic              ms_to_ws_valid;
  logic [31:0]       ms_pc;
  logic [3:0]        ms_gr_we;
  logic [4:0]        ms_dest;
  logic [31:0]       ms_final_result;
  logic [SIDE_W-1:0] ms_side_bus;
  logic [3:0]        ms_fwd_we;
  logic [4:0]        ms_fwd_dest;
  logic              ms_fwd_pending;

  modport slave (
    input  es_to_ms_valid, es_pc, es_gr_we, es_dest, es_alu_result, es_rt_value,
           es_load_op, es_mem_req, es_side_bus, data_sram_data_ok, data_sram_rdata,
           flush, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_final_result,
           ms_side_bus, ms_fwd_we, ms_fwd_dest, ms_fwd_pending
  );

  modport master (
    output es_to_ms_valid, es_pc, es_gr_we, es_dest, es_alu_result, es_rt_value,
           es_load_op, es_mem_req, es_side_bus, data_sram_data_ok, data_sram_rdata,
           flush, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_pc, ms_gr_we, ms_dest, ms_final_result,
           ms_side_bus, ms_fwd_we, ms_fwd_dest, ms_fwd_pending
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: waits for data-SRAM data_ok, aligns load data, drops stale responses after flush.
// `MEM_UNALIGNED_LOAD_EN enables the lwl/lwr merge; otherwise lwl/lwr behave as lw.
module mem_stage #(
  parameter int SIDE_W          = 80,
  parameter int MAX_OUTSTANDING = 3
) (
  input logic   clk,
  input logic   resetn,
  mem_stage_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic              ms_valid, req_pending, buf_valid;
  logic [CNT_W-1:0]  discard_cnt;
  logic [CNT_W+1:0]  cnt_sum;
  logic [31:0]       pc, alu_result, buf_data;
  logic [3:0]        gr_we;
  logic [4:0]        dest;
  logic [6:0]        load_op;
  logic [SIDE_W-1:0] side;
`ifdef MEM_UNALIGNED_LOAD_EN
  logic [31:0]       rt_value;
`endif

  logic drop, ok_live, ms_ready_go, take, capture, is_load;

  assign drop        = bus.data_sram_data_ok && (discard_cnt != '0);
  assign ok_live     = bus.data_sram_data_ok && (discard_cnt == '0);
  assign ms_ready_go = !req_pending || buf_valid || ok_live;
  assign bus.ms_allowin     = !ms_valid || (ms_ready_go && bus.ws_allowin);
  assign bus.ms_to_ws_valid = ms_valid && ms_ready_go && !bus.flush;
  assign take        = ok_live && req_pending && ms_valid && !buf_valid;
  assign capture     = bus.ms_allowin && bus.es_to_ms_valid && !bus.flush;

  // Responses still owed to flushed requests: the one in MEM (if not answered now)
  // and the one EXE issued in the flush cycle itself.
  always_comb begin
    cnt_sum = {2'b00, discard_cnt};
    if (bus.flush && req_pending && !buf_valid && !take) cnt_sum = cnt_sum + 1'b1;
    if (bus.flush && bus.es_to_ms_valid && bus.es_mem_req) cnt_sum = cnt_sum + 1'b1;
    if (drop) cnt_sum = cnt_sum - 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid    <= 1'b0;
      req_pending <= 1'b0;
      buf_valid   <= 1'b0;
      discard_cnt <= '0;
    end else begin
      discard_cnt <= (cnt_sum > (CNT_W+2)'(MAX_OUTSTANDING)) ? CNT_W'(MAX_OUTSTANDING)
                                                              : cnt_sum[CNT_W-1:0];
      if (bus.flush) begin
        ms_valid    <= 1'b0;
        req_pending <= 1'b0;
        buf_valid   <= 1'b0;
      end else if (bus.ms_allowin) begin
        ms_valid    <= bus.es_to_ms_valid;
        req_pending <= bus.es_to_ms_valid && bus.es_mem_req;
        buf_valid   <= 1'b0;
      end else if (take) begin
        // WB stalled in the response cycle: hold the data until it drains
        buf_valid   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      pc         <= bus.es_pc;
      gr_we      <= bus.es_gr_we;
      dest       <= bus.es_dest;
      alu_result <= bus.es_alu_result;
      load_op    <= bus.es_load_op;
      side       <= bus.es_side_bus;
`ifdef MEM_UNALIGNED_LOAD_EN
      rt_value   <= bus.es_rt_value;
`endif
    end
    if (take) buf_data <= bus.data_sram_rdata;
  end

  assert property (@(posedge clk) disable iff (!resetn)
    cnt_sum <= (CNT_W+2)'(MAX_OUTSTANDING));

  logic [31:0] ld, aligned;
  logic [1:0]  a;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign ld = buf_valid ? buf_data : bus.data_sram_rdata;

  always_comb begin
    a       = alu_result[1:0];
    byte_v  = ld[{a, 3'b000} +: 8];
    half_v  = a[1] ? ld[31:16] : ld[15:0];
    aligned = ld;
    case (1'b1)
      load_op[0]: aligned = {{24{byte_v[7]}}, byte_v};
      load_op[1]: aligned = {24'd0, byte_v};
      load_op[2]: aligned = {{16{half_v[15]}}, half_v};
      load_op[3]: aligned = {16'd0, half_v};
      load_op[4]: aligned = ld;
`ifdef MEM_UNALIGNED_LOAD_EN
      load_op[5]: case (a)
        2'd0:    aligned = {ld[7:0],  rt_value[23:0]};
        2'd1:    aligned = {ld[15:0], rt_value[15:0]};
        2'd2:    aligned = {ld[23:0], rt_value[7:0]};
        default: aligned = ld;
      endcase
      load_op[6]: case (a)
        2'd0:    aligned = ld;
        2'd1:    aligned = {rt_value[31:24], ld[31:8]};
        2'd2:    aligned = {rt_value[31:16], ld[31:16]};
        default: aligned = {rt_value[31:8],  ld[31:24]};
      endcase
`else
      load_op[5], load_op[6]: aligned = ld;
`endif
      default: aligned = ld;
    endcase
  end

  assign is_load             = |load_op;
  assign bus.ms_pc           = pc;
  assign bus.ms_gr_we        = gr_we;
  assign bus.ms_dest         = dest;
  assign bus.ms_side_bus     = side;
  assign bus.ms_final_result = is_load ? aligned : alu_result;
  assign bus.ms_fwd_we       = ms_valid ? gr_we : 4'd0;
  assign bus.ms_fwd_dest     = ms_valid ? dest : 5'd0;
  assign bus.ms_fwd_pending  = ms_valid && is_load && !ms_ready_go;
endmodule
